// File: rtl/run_sequencer.sv
// run_sequencer: launches a processor core on one of NPROG programs.
// Sequence: IDLE (core held in reset) -> LOAD (one-cycle PC load strobe)
// -> RUN (count cycles until core_halt) -> FIN (one cycle, done) -> IDLE.
//
// Optional feature: define RUN_SEQUENCER_WATCHDOG_EN to end a RUN that
// reaches TMO counted cycles without halting (timeout=1). Without the macro
// timeout stays 0 and RUN lasts until core_halt or reset.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-high reset
//   req        run request, sampled only in IDLE
//   prog_sel   program index captured with req (clamped to NPROG-1)
//   prog_base  packed start addresses, entry i at [i*D +: D]
//   core_halt  core reached halt, honoured only in RUN
//   core_rst   holds the core in reset (IDLE, FIN)
//   pc_load    one-cycle PC load strobe (LOAD)
//   pc_init    PC value with pc_load, zero otherwise
//   busy       high in LOAD and RUN
//   done       run finished, held until the next accepted req
//   timeout    last run ended by the watchdog
//   cycles     RUN-cycle count of the current or last run (saturating)
// All outputs are registered.

module run_sequencer #(
  parameter int unsigned D     = 12,
  parameter int unsigned NPROG = 4,
  parameter int unsigned CW    = 16,
  parameter int unsigned TMO   = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [$clog2(NPROG)-1:0] prog_sel,
  input  logic [NPROG*D-1:0]       prog_base,
  input  logic                     core_halt,
  output logic                     core_rst,
  output logic                     pc_load,
  output logic [D-1:0]             pc_init,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CW-1:0]            cycles
);

  localparam int unsigned SW = $clog2(NPROG);
  localparam logic [CW-1:0] TMO_C = CW'(TMO);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   sel_cl;
  logic [D-1:0]    base_sel;
  logic [CW-1:0]   cnt_inc;
  logic            limit_hit;

  logic            core_rst_nx;
  logic            pc_load_nx;
  logic [D-1:0]    pc_init_nx;
  logic            busy_nx;
  logic            done_nx;
  logic            timeout_nx;
  logic [CW-1:0]   cycles_nx;

  // Clamp the program index and select its start address.
  always_comb begin
    sel_cl = prog_sel;
    if (32'(prog_sel) >= NPROG) begin
      sel_cl = SW'(NPROG - 1);
    end
    base_sel = '0;
    for (int i = 0; i < int'(NPROG); i++) begin
      if (32'(sel_cl) == 32'(i)) begin
        base_sel = prog_base[i*D +: D];
      end
    end
  end

  // Saturating increment: the count never wraps.
  assign cnt_inc = (cycles == CNT_MAX) ? cycles : cycles + CW'(1);

  // Watchdog limit on the count this RUN cycle would reach; constant 0 when
  // the watchdog is not compiled in.
  assign limit_hit = WDOG_EN && (cnt_inc >= TMO_C);

  // Next state and next registered outputs.
  always_comb begin
    state_nx    = state;
    core_rst_nx = 1'b1;
    pc_load_nx  = 1'b0;
    pc_init_nx  = '0;
    busy_nx     = 1'b0;
    done_nx     = done;
    timeout_nx  = timeout;
    cycles_nx   = cycles;

    case (state)
      IDLE: begin
        if (req) begin
          state_nx    = LOAD;
          core_rst_nx = 1'b0;
          pc_load_nx  = 1'b1;
          pc_init_nx  = base_sel;
          busy_nx     = 1'b1;
          done_nx     = 1'b0;
          timeout_nx  = 1'b0;
          cycles_nx   = '0;
        end
      end

      LOAD: begin
        state_nx    = RUN;
        core_rst_nx = 1'b0;
        busy_nx     = 1'b1;
      end

      RUN: begin
        // Halt wins over the limit and its cycle is not counted.
        if (core_halt) begin
          state_nx = FIN;
          done_nx  = 1'b1;
        end else begin
          cycles_nx = cnt_inc;
          if (limit_hit) begin
            state_nx   = FIN;
            done_nx    = 1'b1;
            timeout_nx = 1'b1;
          end else begin
            core_rst_nx = 1'b0;
            busy_nx     = 1'b1;
          end
        end
      end

      FIN: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      core_rst <= 1'b1;
      pc_load  <= 1'b0;
      pc_init  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      cycles   <= '0;
    end else begin
      state    <= state_nx;
      core_rst <= core_rst_nx;
      pc_load  <= pc_load_nx;
      pc_init  <= pc_init_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      timeout  <= timeout_nx;
      cycles   <= cycles_nx;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: main instance with default parameters,
// plus a small instance (NPROG=3, CW=4, TMO=10) for clamping, saturation
// and, when RUN_SEQUENCER_WATCHDOG_EN is defined, the watchdog.

module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        reset;

  logic        req;
  logic [1:0]  prog_sel;
  logic [47:0] prog_base;
  logic        core_halt;
  logic        core_rst, pc_load, busy, done, timeout;
  logic [11:0] pc_init;
  logic [15:0] cycles;

  logic        req_s;
  logic [1:0]  sel_s;
  logic [35:0] base_s;
  logic        halt_s;
  logic        core_rst_s, pc_load_s, busy_s, done_s, timeout_s;
  logic [11:0] pc_init_s;
  logic [3:0]  cycles_s;

  int vec = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  run_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
    .prog_base(prog_base), .core_halt(core_halt), .core_rst(core_rst),
    .pc_load(pc_load), .pc_init(pc_init), .busy(busy), .done(done),
    .timeout(timeout), .cycles(cycles)
  );

  run_sequencer #(.D(12), .NPROG(3), .CW(4), .TMO(10)) dut_s (
    .clk(clk), .reset(reset), .req(req_s), .prog_sel(sel_s),
    .prog_base(base_s), .core_halt(halt_s), .core_rst(core_rst_s),
    .pc_load(pc_load_s), .pc_init(pc_init_s), .busy(busy_s), .done(done_s),
    .timeout(timeout_s), .cycles(cycles_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; prog_sel = '0; core_halt = 1'b0;
    prog_base = {12'h3FF, 12'h040, 12'h020, 12'h100};
    req_s = 1'b0; sel_s = '0; halt_s = 1'b0;
    base_s = {12'h033, 12'h022, 12'h011};
    #20;
    vec++; if (core_rst !== 1'b1) begin miscmp++; $display("FAIL rst_core_rst got %0h exp 1", core_rst); end
    vec++; if (pc_load !== 1'b0) begin miscmp++; $display("FAIL rst_pc_load got %0h exp 0", pc_load); end
    vec++; if (pc_init !== 12'h000) begin miscmp++; $display("FAIL rst_pc_init got %0h exp 0", pc_init); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL rst_busy got %0h exp 0", busy); end
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL rst_done got %0h exp 0", done); end
    vec++; if (timeout !== 1'b0) begin miscmp++; $display("FAIL rst_timeout got %0h exp 0", timeout); end
    vec++; if (cycles !== 16'd0) begin miscmp++; $display("FAIL rst_cycles got %0d exp 0", cycles); end
    reset = 1'b0;
  endtask

  // First req right after reset release, program 2 at 0x040.
  task automatic test_first_load();
    prog_sel = 2'd2; req = 1'b1;
    tick();
    vec++; if (pc_load !== 1'b1) begin miscmp++; $display("FAIL load_pc_load got %0h exp 1", pc_load); end
    vec++; if (pc_init !== 12'h040) begin miscmp++; $display("FAIL load_pc_init got %0h exp 040", pc_init); end
    vec++; if (busy !== 1'b1) begin miscmp++; $display("FAIL load_busy got %0h exp 1", busy); end
    vec++; if (core_rst !== 1'b0) begin miscmp++; $display("FAIL load_core_rst got %0h exp 0", core_rst); end
    req = 1'b0;
    tick();
    vec++; if (pc_load !== 1'b0) begin miscmp++; $display("FAIL run_pc_load got %0h exp 0", pc_load); end
    vec++; if (pc_init !== 12'h000) begin miscmp++; $display("FAIL run_pc_init got %0h exp 0", pc_init); end
    vec++; if (busy !== 1'b1) begin miscmp++; $display("FAIL run_busy got %0h exp 1", busy); end
    vec++; if (cycles !== 16'd0) begin miscmp++; $display("FAIL run_cycles0 got %0d exp 0", cycles); end
  endtask

  // Halt 7 cycles after pc_load: 6 counted cycles.
  task automatic test_halt();
    repeat (6) tick();
    vec++; if (cycles !== 16'd6) begin miscmp++; $display("FAIL halt_pre_cycles got %0d exp 6", cycles); end
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    vec++; if (done !== 1'b1) begin miscmp++; $display("FAIL halt_done got %0h exp 1", done); end
    vec++; if (cycles !== 16'd6) begin miscmp++; $display("FAIL halt_cycles got %0d exp 6", cycles); end
    vec++; if (timeout !== 1'b0) begin miscmp++; $display("FAIL halt_timeout got %0h exp 0", timeout); end
    vec++; if (core_rst !== 1'b1) begin miscmp++; $display("FAIL halt_core_rst got %0h exp 1", core_rst); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL halt_busy got %0h exp 0", busy); end
    tick();
    // Halt in IDLE must be ignored; done holds.
    core_halt = 1'b1;
    repeat (3) tick();
    core_halt = 1'b0;
    vec++; if (done !== 1'b1) begin miscmp++; $display("FAIL idle_done_hold got %0h exp 1", done); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL idle_busy got %0h exp 0", busy); end
    vec++; if (core_rst !== 1'b1) begin miscmp++; $display("FAIL idle_core_rst got %0h exp 1", core_rst); end
    vec++; if (cycles !== 16'd6) begin miscmp++; $display("FAIL idle_cycles got %0d exp 6", cycles); end
  endtask

  // req during RUN and FIN is ignored; back-to-back run afterwards.
  task automatic test_req_ignored();
    prog_sel = 2'd0; req = 1'b1;
    tick();
    vec++; if (pc_init !== 12'h100) begin miscmp++; $display("FAIL b2b_pc_init got %0h exp 100", pc_init); end
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL b2b_done_clr got %0h exp 0", done); end
    vec++; if (cycles !== 16'd0) begin miscmp++; $display("FAIL b2b_cycles_clr got %0d exp 0", cycles); end
    req = 1'b0;
    repeat (3) tick();
    vec++; if (cycles !== 16'd2) begin miscmp++; $display("FAIL ign_cycles2 got %0d exp 2", cycles); end
    prog_sel = 2'd3; req = 1'b1;
    tick();
    vec++; if (cycles !== 16'd3) begin miscmp++; $display("FAIL ign_cycles3 got %0d exp 3", cycles); end
    vec++; if (pc_load !== 1'b0) begin miscmp++; $display("FAIL ign_pc_load got %0h exp 0", pc_load); end
    tick();
    vec++; if (cycles !== 16'd4) begin miscmp++; $display("FAIL ign_cycles4 got %0d exp 4", cycles); end
    vec++; if (busy !== 1'b1) begin miscmp++; $display("FAIL ign_busy got %0h exp 1", busy); end
    req = 1'b0; core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    vec++; if (done !== 1'b1) begin miscmp++; $display("FAIL ign_done got %0h exp 1", done); end
    vec++; if (cycles !== 16'd4) begin miscmp++; $display("FAIL ign_fin_cycles got %0d exp 4", cycles); end
    req = 1'b1;
    tick();
    vec++; if (pc_load !== 1'b0) begin miscmp++; $display("FAIL fin_req_pc_load got %0h exp 0", pc_load); end
    vec++; if (done !== 1'b1) begin miscmp++; $display("FAIL fin_req_done got %0h exp 1", done); end
    tick();
    req = 1'b0;
    vec++; if (pc_load !== 1'b1) begin miscmp++; $display("FAIL b2b2_pc_load got %0h exp 1", pc_load); end
    vec++; if (pc_init !== 12'h3FF) begin miscmp++; $display("FAIL b2b2_pc_init got %0h exp 3ff", pc_init); end
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL b2b2_done got %0h exp 0", done); end
  endtask

  // Asynchronous reset mid-RUN, then a clean run.
  task automatic test_async_reset();
    repeat (3) tick();
    vec++; if (cycles !== 16'd2) begin miscmp++; $display("FAIL ar_pre_cycles got %0d exp 2", cycles); end
    #3 reset = 1'b1;
    #1;
    vec++; if (core_rst !== 1'b1) begin miscmp++; $display("FAIL ar_core_rst got %0h exp 1", core_rst); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL ar_busy got %0h exp 0", busy); end
    vec++; if (cycles !== 16'd0) begin miscmp++; $display("FAIL ar_cycles got %0d exp 0", cycles); end
    reset = 1'b0;
    prog_sel = 2'd1; req = 1'b1;
    tick();
    req = 1'b0;
    vec++; if (pc_load !== 1'b1) begin miscmp++; $display("FAIL ar_pc_load got %0h exp 1", pc_load); end
    vec++; if (pc_init !== 12'h020) begin miscmp++; $display("FAIL ar_pc_init got %0h exp 020", pc_init); end
    repeat (4) tick();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    vec++; if (done !== 1'b1) begin miscmp++; $display("FAIL ar_run_done got %0h exp 1", done); end
    vec++; if (cycles !== 16'd3) begin miscmp++; $display("FAIL ar_run_cycles got %0d exp 3", cycles); end
    tick();
  endtask

  // Out-of-range index on the 3-program instance clamps to entry 2.
  task automatic test_clamp();
    sel_s = 2'd3; req_s = 1'b1;
    tick();
    req_s = 1'b0;
    vec++; if (pc_load_s !== 1'b1) begin miscmp++; $display("FAIL clamp_pc_load got %0h exp 1", pc_load_s); end
    vec++; if (pc_init_s !== 12'h033) begin miscmp++; $display("FAIL clamp_pc_init got %0h exp 033", pc_init_s); end
    tick();
  endtask

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  // TMO=10 expiry, then halt coinciding with the limit.
  task automatic test_watchdog();
    repeat (9) tick();
    vec++; if (cycles_s !== 4'd9) begin miscmp++; $display("FAIL wd_cycles9 got %0d exp 9", cycles_s); end
    vec++; if (done_s !== 1'b0) begin miscmp++; $display("FAIL wd_done_pre got %0h exp 0", done_s); end
    tick();
    vec++; if (timeout_s !== 1'b1) begin miscmp++; $display("FAIL wd_timeout got %0h exp 1", timeout_s); end
    vec++; if (done_s !== 1'b1) begin miscmp++; $display("FAIL wd_done got %0h exp 1", done_s); end
    vec++; if (cycles_s !== 4'd10) begin miscmp++; $display("FAIL wd_cycles got %0d exp 10", cycles_s); end
    vec++; if (core_rst_s !== 1'b1) begin miscmp++; $display("FAIL wd_core_rst got %0h exp 1", core_rst_s); end
    tick();
    vec++; if (timeout_s !== 1'b1) begin miscmp++; $display("FAIL wd_timeout_hold got %0h exp 1", timeout_s); end
    sel_s = 2'd0; req_s = 1'b1;
    tick();
    req_s = 1'b0;
    vec++; if (pc_init_s !== 12'h011) begin miscmp++; $display("FAIL wd2_pc_init got %0h exp 011", pc_init_s); end
    vec++; if (timeout_s !== 1'b0) begin miscmp++; $display("FAIL wd2_timeout_clr got %0h exp 0", timeout_s); end
    repeat (10) tick();
    halt_s = 1'b1;
    tick();
    halt_s = 1'b0;
    vec++; if (timeout_s !== 1'b0) begin miscmp++; $display("FAIL wd_tie_timeout got %0h exp 0", timeout_s); end
    vec++; if (done_s !== 1'b1) begin miscmp++; $display("FAIL wd_tie_done got %0h exp 1", done_s); end
    vec++; if (cycles_s !== 4'd9) begin miscmp++; $display("FAIL wd_tie_cycles got %0d exp 9", cycles_s); end
    tick();
  endtask
`else
  // CW=4: 20 RUN cycles saturate at 15.
  task automatic test_saturation();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) begin
        vec++; if (cycles_s !== 4'd10) begin miscmp++; $display("FAIL sat_cycles10 got %0d exp 10", cycles_s); end
      end
    end
    vec++; if (cycles_s !== 4'd15) begin miscmp++; $display("FAIL sat_cycles20 got %0d exp 15", cycles_s); end
    vec++; if (busy_s !== 1'b1) begin miscmp++; $display("FAIL sat_busy got %0h exp 1", busy_s); end
    halt_s = 1'b1;
    tick();
    halt_s = 1'b0;
    vec++; if (done_s !== 1'b1) begin miscmp++; $display("FAIL sat_done got %0h exp 1", done_s); end
    vec++; if (cycles_s !== 4'd15) begin miscmp++; $display("FAIL sat_fin_cycles got %0d exp 15", cycles_s); end
    vec++; if (timeout_s !== 1'b0) begin miscmp++; $display("FAIL sat_timeout got %0h exp 0", timeout_s); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_first_load();
    test_halt();
    test_req_ignored();
    test_async_reset();
    test_clamp();
`ifdef RUN_SEQUENCER_WATCHDOG_EN
    test_watchdog();
`else
    test_saturation();
`endif
    vec++; if (timeout !== 1'b0) begin miscmp++; $display("FAIL main_timeout got %0h exp 0", timeout); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL bench_time_limit got expired exp finish");
    $fatal(1, "time limit");
  end

endmodule
